csr_trap_unit: RTL

//  Parametrised machine-mode CSR file and trap controller for the QianTang core; successor to the fixed 3-interrupt CSR block.

---
 rtl/csr_trap_unit.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: synchronous exceptions, standard and
// platform-local interrupts, mret, vectored mtvec and mcycle/minstret counters.
module csr_trap_unit #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     NUM_LIRQ    = 4,
    parameter int unsigned     VECTORED_EN = 1,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input  logic                clk_sys_i,
    input  logic                rst_n_i,
    input  logic                csr_rd_en_i,
    input  logic [11:0]         csr_addr_i,
    output logic [XLEN-1:0]     csr_rd_data_o,
    input  logic                csr_wr_en_i,
    input  logic [1:0]          csr_op_i,
    input  logic [XLEN-1:0]     csr_wr_data_i,
    output logic                csr_illegal_o,
    input  logic [XLEN-1:0]     pc_i,
    input  logic                instr_retire_i,
    input  logic                exc_valid_i,
    input  logic [4:0]          exc_cause_i,
    input  logic [XLEN-1:0]     exc_tval_i,
    input  logic                msip_i,
    input  logic                mtip_i,
    input  logic                meip_i,
    input  logic [NUM_LIRQ-1:0] lirq_i,
    input  logic                mret_i,
    output logic                trap_enter_o,
    output logic                trap_exit_o,
    output logic [XLEN-1:0]     trap_pc_o,
    output logic [XLEN-1:0]     mepc_o
);

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    function automatic logic [XLEN-1:0] irq_mask();
        logic [XLEN-1:0] m;
        m = '0;
        m[3]  = 1'b1;
        m[7]  = 1'b1;
        m[11] = 1'b1;
        m[16 +: NUM_LIRQ] = '1;
        return m;
    endfunction

    function automatic logic [XLEN-1:0] misa_value();
        logic [XLEN-1:0] m;
        m = '0;
        m[XLEN-1 -: 2] = (XLEN == 64) ? 2'd2 : 2'd1;
        m[8] = 1'b1;
        return m;
    endfunction

    localparam logic [XLEN-1:0] IRQ_MASK    = irq_mask();
    localparam logic [XLEN-1:0] MISA_VAL    = misa_value();
    localparam logic [XLEN-1:0] CNTINH_MASK = XLEN'(5);

    localparam logic [11:0] A_MSTATUS   = 12'h300, A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304, A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MCNTINH   = 12'h320, A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341, A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343, A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00, A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MVENDORID = 12'hF11, A_MARCHID  = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13, A_MHARTID  = 12'hF14;

    logic            mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d, mip_q, mip_d, mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d, mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [XLEN-1:0] mcntinh_q, mcntinh_d;

    csr_op_e         op;
    logic            defined, wr_active, illegal, csr_we;
    logic [XLEN-1:0] rd_val, wval;
    logic [1:0]      mtvec_mode;

    logic [NUM_LIRQ-1:0] lirq_pend;
    logic            msi_pend, mti_pend, mei_pend, irq_hit, take_irq;
    logic [4:0]      irq_code, trap_code;
    logic            trap_enter, mret_take;
    logic [XLEN-1:0] tvec_base, trap_target, trap_cause;

    always_comb begin
        rd_val  = '0;
        defined = 1'b1;
        case (csr_addr_i)
            A_MSTATUS: begin
                rd_val[3]     = mstatus_mie_q;
                rd_val[7]     = mstatus_mpie_q;
                rd_val[12:11] = 2'b11;
            end
            A_MISA:     rd_val = MISA_VAL;
            A_MIE:      rd_val = mie_q;
            A_MTVEC:    rd_val = mtvec_q;
            A_MCNTINH:  rd_val = mcntinh_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_q;
            A_MCAUSE:   rd_val = mcause_q;
            A_MTVAL:    rd_val = mtval_q;
            A_MIP:      rd_val = mip_q;
            A_MCYCLE:   rd_val = mcycle_q;
            A_MINSTRET: rd_val = minstret_q;
            A_MVENDORID, A_MARCHID, A_MIMPID: rd_val = '0;
            A_MHARTID:  rd_val = HART_ID;
            default:    defined = 1'b0;
        endcase
    end

    assign op        = csr_op_e'(csr_op_i);
    assign wr_active = csr_wr_en_i && (op != OP_NONE);
    assign illegal   = (csr_rd_en_i || csr_wr_en_i)
                     && (!defined || (wr_active && (csr_addr_i[11:10] == 2'b11)));

    always_comb begin
        case (op)
            OP_WRITE: wval = csr_wr_data_i;
            OP_SET:   wval = rd_val | csr_wr_data_i;
            OP_CLEAR: wval = rd_val & ~csr_wr_data_i;
            default:  wval = rd_val;
        endcase
    end

    assign msi_pend  = mstatus_mie_q && mie_q[3]  && mip_q[3];
    assign mti_pend  = mstatus_mie_q && mie_q[7]  && mip_q[7];
    assign mei_pend  = mstatus_mie_q && mie_q[11] && mip_q[11];
    assign lirq_pend = mip_q[16 +: NUM_LIRQ] & mie_q[16 +: NUM_LIRQ] & {NUM_LIRQ{mstatus_mie_q}};

    always_comb begin
        irq_hit  = 1'b0;
        irq_code = '0;
        if (mei_pend) begin
            irq_hit  = 1'b1;
            irq_code = 5'd11;
        end else if (msi_pend) begin
            irq_hit  = 1'b1;
            irq_code = 5'd3;
        end else if (mti_pend) begin
            irq_hit  = 1'b1;
            irq_code = 5'd7;
        end else begin
            for (int unsigned i = 0; i < NUM_LIRQ; i++) begin
                if (!irq_hit && lirq_pend[i]) begin
                    irq_hit  = 1'b1;
                    irq_code = 5'(16 + i);
                end
            end
        end
    end

    // Outputs are held low while reset is asserted, even if trap inputs are active.
    assign trap_enter = rst_n_i && (exc_valid_i || irq_hit);
    assign take_irq   = !exc_valid_i && irq_hit;
    assign trap_code  = exc_valid_i ? exc_cause_i : irq_code;
    assign mret_take  = rst_n_i && mret_i && !trap_enter;
    assign csr_we     = wr_active && !illegal && !trap_enter && !mret_i;

    assign tvec_base   = mtvec_q & ~XLEN'(3);
    assign trap_target = ((VECTORED_EN != 0) && mtvec_q[0] && take_irq)
                       ? tvec_base + (XLEN'(trap_code) << 2) : tvec_base;

    always_comb begin
        trap_cause         = '0;
        trap_cause[4:0]    = trap_code;
        trap_cause[XLEN-1] = take_irq;
    end

    assign mtvec_mode = ((VECTORED_EN != 0) && (wval[1:0] == 2'b01)) ? 2'b01 : 2'b00;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcntinh_d      = mcntinh_q;
        mcycle_d       = mcycle_q + {{(XLEN-1){1'b0}}, ~mcntinh_q[0]};
        minstret_d     = minstret_q + {{(XLEN-1){1'b0}}, instr_retire_i & ~mcntinh_q[2]};
        mip_d                   = '0;
        mip_d[3]                = msip_i;
        mip_d[7]                = mtip_i;
        mip_d[11]               = meip_i;
        mip_d[16 +: NUM_LIRQ]   = lirq_i;

        if (trap_enter) begin
            mepc_d         = pc_i & ~XLEN'(1);
            mcause_d       = trap_cause;
            mtval_d        = exc_valid_i ? exc_tval_i : '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr_i)
                A_MSTATUS: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                A_MIE:      mie_d      = wval & IRQ_MASK;
                A_MTVEC:    mtvec_d    = (wval & ~XLEN'(3)) | XLEN'(mtvec_mode);
                A_MCNTINH:  mcntinh_d  = wval & CNTINH_MASK;
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = wval & ~XLEN'(1);
                A_MCAUSE:   mcause_d   = wval;
                A_MTVAL:    mtval_d    = wval;
                A_MCYCLE:   mcycle_d   = wval;
                A_MINSTRET: minstret_d = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= RESET_VEC & ~XLEN'(3);
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            mcntinh_q      <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            mcntinh_q      <= mcntinh_d;
        end
    end

    assign csr_rd_data_o = (csr_rd_en_i && !illegal) ? rd_val : '0;
    assign csr_illegal_o = illegal;
    assign trap_enter_o  = trap_enter;
    assign trap_exit_o   = mret_take;
    assign trap_pc_o     = trap_enter ? trap_target : (mret_take ? mepc_q : '0);
    assign mepc_o        = mepc_q;

endmodule
